// File: rtl/instr_fetch.sv
// instr_fetch: RV32I instruction fetch stage.
// The stage issues one word read at a time, holds the returned instruction,
// and slices it into decode fields. PC redirects from execute override
// in-flight fetches by dropping the stale response.
// Build option: define IFETCH_PERF_EN to add o_fetch_count, which counts
// decode handshakes.
module instr_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_nreset,
    output logic                  o_imem_req_valid,
    input  logic                  i_imem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    input  logic                  i_imem_rsp_valid,
    input  logic [31:0]           i_imem_rdata,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_dec_valid,
    input  logic                  i_dec_ready,
`ifdef IFETCH_PERF_EN
    output logic [31:0]           o_fetch_count,
`endif
    output logic [ADDR_WIDTH-1:0] o_dec_pc,
    output logic [6:0]            o_opcode,
    output logic [4:0]            o_rd,
    output logic [2:0]            o_funct3,
    output logic [4:0]            o_rs1,
    output logic [4:0]            o_rs2,
    output logic [6:0]            o_funct7
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic                  r_drop;
    logic [31:0]           r_ir;
    logic [ADDR_WIDTH-1:0] r_dec_pc;
    logic                  r_dec_valid;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_fetch_pc_nxt;
    logic                  w_drop_nxt;
    logic [31:0]           w_ir_nxt;
    logic [ADDR_WIDTH-1:0] w_dec_pc_nxt;
    logic                  w_dec_valid_nxt;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [ADDR_WIDTH-1:0] w_pc_inc;

    assign w_target = i_redirect_pc & ALIGN_MASK;
    assign w_pc_inc = r_fetch_pc + PC_STEP;

    // State and datapath registers; reset overrides everything, including WAIT
    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_PC & ALIGN_MASK;
            r_drop      <= 1'b0;
            r_ir        <= '0;
            r_dec_pc    <= '0;
            r_dec_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_drop      <= w_drop_nxt;
            r_ir        <= w_ir_nxt;
            r_dec_pc    <= w_dec_pc_nxt;
            r_dec_valid <= w_dec_valid_nxt;
        end
    end

    // Next-state logic; a redirect takes priority over normal progress in every state
    always_comb begin
        w_state_nxt     = r_state;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_drop_nxt      = r_drop;
        w_ir_nxt        = r_ir;
        w_dec_pc_nxt    = r_dec_pc;
        w_dec_valid_nxt = r_dec_valid;
        case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
                if (i_redirect_valid) w_fetch_pc_nxt = w_target;
            end
            REQ: begin
                if (i_redirect_valid) begin
                    w_fetch_pc_nxt = w_target;
                    if (i_imem_req_ready) begin
                        // request already went out with the old PC; kill its data
                        w_drop_nxt  = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end else if (i_imem_req_ready) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (i_redirect_valid) begin
                    w_fetch_pc_nxt = w_target;
                    if (i_imem_rsp_valid) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = REQ;
                    end else begin
                        w_drop_nxt = 1'b1;
                    end
                end else if (i_imem_rsp_valid) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = REQ;
                    end else begin
                        w_ir_nxt        = i_imem_rdata;
                        w_dec_pc_nxt    = r_fetch_pc;
                        w_fetch_pc_nxt  = w_pc_inc;
                        w_dec_valid_nxt = 1'b1;
                        w_state_nxt     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (i_redirect_valid) begin
                    w_dec_valid_nxt = 1'b0;
                    w_fetch_pc_nxt  = w_target;
                    w_state_nxt     = REQ;
                end else if (r_dec_valid && i_dec_ready) begin
                    w_dec_valid_nxt = 1'b0;
                    w_state_nxt     = REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] r_fetch_count;

    // Count decode handshakes; a handshake coincident with a redirect still counts
    always_ff @(posedge i_clk) begin
        if (!i_nreset)                      r_fetch_count <= '0;
        else if (r_dec_valid && i_dec_ready) r_fetch_count <= r_fetch_count + 32'd1;
    end

    assign o_fetch_count = r_fetch_count;
`endif

    assign o_imem_req_valid = (r_state == REQ);
    assign o_imem_addr      = r_fetch_pc;
    assign o_dec_valid      = r_dec_valid;
    assign o_dec_pc         = r_dec_pc;
    assign o_opcode         = r_ir[6:0];
    assign o_rd             = r_ir[11:7];
    assign o_funct3         = r_ir[14:12];
    assign o_rs1            = r_ir[19:15];
    assign o_rs2            = r_ir[24:20];
    assign o_funct7         = r_ir[31:25];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: decode-field vector table, directed redirect/reset
// sequences, then randomized traffic against a transaction-level model.
// Define IFETCH_PERF_EN to also exercise o_fetch_count.
module tb_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nreset, ready, rsp_valid, redir, dec_ready;
    logic [31:0] rdata, redir_pc;

    logic        req_valid, dec_valid;
    logic [31:0] addr, dec_pc;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;

    logic        d2_req_valid, d2_dec_valid;
    logic [31:0] d2_addr, d2_dec_pc;
    logic [6:0]  d2_opcode, d2_funct7;
    logic [4:0]  d2_rd, d2_rs1, d2_rs2;
    logic [2:0]  d2_funct3;
`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count, d2_fetch_count;
`endif

    instr_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .i_clk(clk), .i_nreset(nreset),
        .o_imem_req_valid(req_valid), .i_imem_req_ready(ready), .o_imem_addr(addr),
        .i_imem_rsp_valid(rsp_valid), .i_imem_rdata(rdata),
        .i_redirect_valid(redir), .i_redirect_pc(redir_pc),
        .o_dec_valid(dec_valid), .i_dec_ready(dec_ready),
`ifdef IFETCH_PERF_EN
        .o_fetch_count(fetch_count),
`endif
        .o_dec_pc(dec_pc), .o_opcode(opcode), .o_rd(rd), .o_funct3(funct3),
        .o_rs1(rs1), .o_rs2(rs2), .o_funct7(funct7)
    );

    // Same stimulus, wrap-around reset PC
    instr_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .i_clk(clk), .i_nreset(nreset),
        .o_imem_req_valid(d2_req_valid), .i_imem_req_ready(ready), .o_imem_addr(d2_addr),
        .i_imem_rsp_valid(rsp_valid), .i_imem_rdata(rdata),
        .i_redirect_valid(redir), .i_redirect_pc(redir_pc),
        .o_dec_valid(d2_dec_valid), .i_dec_ready(dec_ready),
`ifdef IFETCH_PERF_EN
        .o_fetch_count(d2_fetch_count),
`endif
        .o_dec_pc(d2_dec_pc), .o_opcode(d2_opcode), .o_rd(d2_rd), .o_funct3(d2_funct3),
        .o_rs1(d2_rs1), .o_rs2(d2_rs2), .o_funct7(d2_funct7)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task step;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [63:0] snap();
        return {dec_pc, 1'b0, funct7, rs2, rs1, funct3, rd, opcode};
    endfunction

    // Wait for a request, accept it, return word after lat cycles; lands in HOLD
    task automatic fetch_to_hold(input logic [31:0] word, input logic [31:0] exp_addr,
                                 input int lat, input string tag);
        int n = 0;
        while (!req_valid && n < 10) begin step; n++; end
        chk({tag, "_reqv"}, req_valid, 1);
        chk({tag, "_addr"}, addr, exp_addr);
        ready = 1'b1; step; ready = 1'b0;
        chk({tag, "_wait_noreq"}, req_valid, 0);
        repeat (lat - 1) step;
        rsp_valid = 1'b1; rdata = word; step; rsp_valid = 1'b0; rdata = '0;
        chk({tag, "_decv"}, dec_valid, 1);
        chk({tag, "_decpc"}, dec_pc, exp_addr);
    endtask

    // Stall for hold cycles, checking stability, then consume
    task automatic hold_consume(input int hold, input string tag);
        logic [63:0] s;
        s = snap();
        dec_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step;
            chk({tag, "_stable"}, snap(), s);
            chk({tag, "_hold_noreq"}, req_valid, 0);
            chk({tag, "_hold_decv"}, dec_valid, 1);
        end
        dec_ready = 1'b1; step; dec_ready = 1'b0;
        chk({tag, "_consumed"}, dec_valid, 0);
        chk({tag, "_nextreq"}, req_valid, 1);
    endtask

    typedef struct {
        logic [31:0] word;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        int          lat;
        int          hold;
    } vec_t;

    vec_t tv[6];

    // Model state for the random phase
    logic        m_idle, m_out, m_stale, m_hold;
    logic [31:0] m_pc, m_out_addr, m_hold_pc, m_tgt, w;
    int          m_count;
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_cnt;

    initial begin
        nreset = 1'b0; ready = 1'b0; rsp_valid = 1'b0; redir = 1'b0; dec_ready = 1'b0;
        rdata = '0; redir_pc = '0;

        tv[0] = '{32'h00A3_02B3, 7'h33, 5'd5,  3'd0, 5'd6,  5'd10, 7'h00, 1, 0};
        tv[1] = '{32'hFFFF_FFFF, 7'h7F, 5'd31, 3'd7, 5'd31, 5'd31, 7'h7F, 2, 5};
        tv[2] = '{32'hFE01_0113, 7'h13, 5'd2,  3'd0, 5'd2,  5'd0,  7'h7F, 3, 1};
        tv[3] = '{32'h40B5_0533, 7'h33, 5'd10, 3'd0, 5'd10, 5'd11, 7'h20, 1, 2};
        tv[4] = '{32'h00C5_A023, 7'h23, 5'd0,  3'd2, 5'd11, 5'd12, 7'h00, 2, 0};
        tv[5] = '{32'h0000_0000, 7'h00, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 1, 0};

        step; step;
        nreset = 1'b1;
        chk("rst_reqv", req_valid, 0);
        chk("rst_decv", dec_valid, 0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_fields", snap(), 64'h0);
        chk("rst_d2_addr", d2_addr, 32'hFFFF_FFFC);
`ifdef IFETCH_PERF_EN
        chk("rst_count", fetch_count, 0);
`endif
        step;
        chk("idle_to_req", req_valid, 1);

        // Decode-field table
        for (int i = 0; i < 6; i++) begin
            fetch_to_hold(tv[i].word, 32'(4 * i), tv[i].lat, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_op", i),  opcode, tv[i].op);
            chk($sformatf("vec%0d_rd", i),  rd,     tv[i].rd);
            chk($sformatf("vec%0d_f3", i),  funct3, tv[i].f3);
            chk($sformatf("vec%0d_rs1", i), rs1,    tv[i].rs1);
            chk($sformatf("vec%0d_rs2", i), rs2,    tv[i].rs2);
            chk($sformatf("vec%0d_f7", i),  funct7, tv[i].f7);
            if (i == 0) chk("d2_decpc", d2_dec_pc, 32'hFFFF_FFFC);
            hold_consume(tv[i].hold, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_next_addr", i), addr, 32'(4 * (i + 1)));
            if (i == 0) chk("d2_wrap_addr", d2_addr, 32'h0);
        end

        // Redirect while waiting: response discarded
        ready = 1'b1; step; ready = 1'b0;
        redir = 1'b1; redir_pc = 32'h103; step; redir = 1'b0;
        step;
        rsp_valid = 1'b1; rdata = 32'hFFFF_FFFF; step; rsp_valid = 1'b0;
        chk("rw_decv", dec_valid, 0);
        chk("rw_reqv", req_valid, 1);
        chk("rw_addr", addr, 32'h100);
        step;
        chk("rw_decv2", dec_valid, 0);

        // Redirect coincident with request accept
        ready = 1'b1; redir = 1'b1; redir_pc = 32'h40; step; ready = 1'b0; redir = 1'b0;
        chk("ra_wait", req_valid, 0);
        rsp_valid = 1'b1; rdata = 32'hDEAD_BEEF; step; rsp_valid = 1'b0;
        chk("ra_decv", dec_valid, 0);
        chk("ra_addr", addr, 32'h40);
        fetch_to_hold(32'h00C5_A023, 32'h40, 1, "ra_fetch");
        hold_consume(0, "ra_fetch");
        chk("ra_next", addr, 32'h44);

        // Reset in WAIT
        ready = 1'b1; step; ready = 1'b0;
        nreset = 1'b0; step; nreset = 1'b1;
        chk("rwait_decv", dec_valid, 0);
        chk("rwait_reqv", req_valid, 0);
        chk("rwait_fields", snap(), 64'h0);
        chk("rwait_addr", addr, 32'h0);
`ifdef IFETCH_PERF_EN
        chk("rwait_count", fetch_count, 0);
`endif
        step;
        chk("rwait_req", req_valid, 1);
        chk("rwait_req_addr", addr, 32'h0);

        // Three handshakes plus one dropped response, then reset in HOLD
        for (int i = 0; i < 3; i++) begin
            fetch_to_hold(tv[i].word, 32'(4 * i), 1, "perf");
            hold_consume(0, "perf");
        end
        ready = 1'b1; step; ready = 1'b0;
        redir = 1'b1; redir_pc = 32'h200; step; redir = 1'b0;
        rsp_valid = 1'b1; rdata = 32'h1234_5678; step; rsp_valid = 1'b0;
        chk("perf_drop_decv", dec_valid, 0);
`ifdef IFETCH_PERF_EN
        chk("perf_count3", fetch_count, 3);
`endif
        fetch_to_hold(32'hFFFF_FFFF, 32'h200, 2, "rhold");
        nreset = 1'b0; step; nreset = 1'b1;
        chk("rhold_decv", dec_valid, 0);
        chk("rhold_fields", snap(), 64'h0);
        chk("rhold_reqv", req_valid, 0);
`ifdef IFETCH_PERF_EN
        chk("rhold_count", fetch_count, 0);
`endif
        step;
        chk("rhold_req_addr", addr, 32'h0);

        // Randomized traffic against the transaction model
        nreset = 1'b0; step; nreset = 1'b1;
        m_idle = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_hold = 1'b0;
        m_pc = 32'h0; m_out_addr = '0; m_hold_pc = '0; m_count = 0;
        pend = 1'b0; pend_addr = '0; pend_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            logic exp_req, acc, hs;
            exp_req = !m_idle && !m_out && !m_hold;
            chk("rnd_reqv", req_valid, exp_req);
            chk("rnd_decv", dec_valid, m_hold);
            if (exp_req) chk("rnd_addr", addr, m_pc);
            if (m_hold) begin
                w = mem(m_hold_pc);
                chk("rnd_decpc", dec_pc, m_hold_pc);
                chk("rnd_fields", {funct7, rs2, rs1, funct3, rd, opcode}, w);
            end

            ready     = ($urandom % 2) == 0;
            dec_ready = ($urandom % 3) != 0;
            redir     = ($urandom % 12) == 0;
            redir_pc  = ($urandom % 2) ? $urandom : (32'hFFFF_FFF0 + ($urandom % 16));
            rsp_valid = 1'b0;
            rdata     = $urandom;
            if (pend) begin
                if (pend_cnt == 0) begin
                    rsp_valid = 1'b1;
                    rdata     = mem(pend_addr);
                    pend      = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            acc = exp_req && ready;
            if (acc) begin
                pend      = 1'b1;
                pend_addr = addr;
                pend_cnt  = $urandom_range(0, 2);
            end
            hs = m_hold && dec_ready;
            if (hs) m_count++;

            m_idle = 1'b0;
            if (redir) begin
                m_tgt = redir_pc & ~32'd3;
                if (rsp_valid)  m_out = 1'b0;
                else if (m_out) m_stale = 1'b1;
                if (acc) begin m_out = 1'b1; m_stale = 1'b1; m_out_addr = m_pc; end
                m_hold = 1'b0;
                m_pc   = m_tgt;
            end else begin
                if (hs) m_hold = 1'b0;
                if (rsp_valid) begin
                    m_out = 1'b0;
                    if (!m_stale) begin
                        m_hold    = 1'b1;
                        m_hold_pc = m_out_addr;
                        m_pc      = m_out_addr + 32'd4;
                    end
                    m_stale = 1'b0;
                end
                if (acc) begin m_out = 1'b1; m_out_addr = m_pc; m_stale = 1'b0; end
            end
            step;
        end
`ifdef IFETCH_PERF_EN
        chk("rnd_count", fetch_count, 64'(m_count));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage for the RV32I core. Issues word reads to instruction memory, holds one fetched instruction, and slices it into opcode/funct3/funct7/register fields for the CONTROLLER and register file. Sits upstream of the decode/control path and accepts PC redirects from the execute stage. One outstanding memory request at a time.

Parameters:
ADDR_WIDTH, 32, width of PC and instruction-memory address
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all logic on posedge
nreset  in  1  synchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  ADDR_WIDTH  fetch address, word aligned
imem_rsp_valid  in  1  read data valid; at most one per accepted request, at least 1 cycle after acceptance
imem_rdata  in  32  instruction word
redirect_valid  in  1  PC redirect (branch/jump)
redirect_pc  in  ADDR_WIDTH  redirect target
dec_valid  out  1  decoded fields valid
dec_ready  in  1  decode stage accepts
dec_pc  out  ADDR_WIDTH  PC of held instruction
opcode  out  7  ir[6:0]
rd  out  5  ir[11:7]
funct3  out  3  ir[14:12]
rs1  out  5  ir[19:15]
rs2  out  5  ir[24:20]
funct7  out  7  ir[31:25]

Behaviour:
- Reset: nreset sampled low at posedge -> state IDLE, fetch_pc=RESET_PC, drop=0, ir=0, dec_pc=0, dec_valid=0. All field outputs 0. imem_req_valid=0. Reset wins over every other input in any state, including WAIT; a response arriving after reset release for a pre-reset request is ignored only if drop was set (bench must not deliver one).
- imem_req_valid = (state==REQ); imem_addr = fetch_pc (registered, low 2 bits always 0).
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: next cycle -> REQ.
- REQ: on imem_req_ready -> WAIT.
- WAIT: on imem_rsp_valid: if drop, discard, clear drop, -> REQ; else ir<=imem_rdata, dec_pc<=fetch_pc, fetch_pc<=fetch_pc+4, dec_valid<=1, -> HOLD.
- HOLD: outputs stable while dec_ready=0. On dec_valid&&dec_ready: dec_valid<=0, -> REQ. No new request issued while in HOLD.
- Field outputs are combinational slices of ir; they hold last value when dec_valid=0.
- PC arithmetic modulo 2^ADDR_WIDTH: 0xFFFF_FFFC+4 -> 0x0000_0000.
- Redirect (highest priority after reset), target = {redirect_pc[ADDR_WIDTH-1:2],2'b00}:
  IDLE/REQ without req accept: fetch_pc<=target, -> REQ.
  REQ with imem_req_ready same cycle: fetch_pc<=target, drop<=1, -> WAIT.
  WAIT: fetch_pc<=target; if imem_rsp_valid same cycle, discard, -> REQ; else drop<=1, stay WAIT.
  HOLD: dec_valid<=0, fetch_pc<=target, -> REQ; a coincident dec_ready handshake counts as consumed.
- Minimum latency: request accept to dec_valid = rsp latency + 1 cycle.

Optional Feature:
Macro IFETCH_PERF_EN. Defined: adds output port fetch_count (32 bits), reset 0, increments by 1 (wrapping) on each dec_valid&&dec_ready handshake; dropped responses not counted. Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, memory ready=1, rsp 1 cycle later with 0x00A302B3 -> imem_addr=0x0, dec_valid=1, dec_pc=0x0, opcode=0x33, rd=5, funct3=0, rs1=6, rs2=10, funct7=0; next request addr 0x4 after handshake.
- dec_ready held 0 for 5 cycles in HOLD -> all fields and dec_pc stable, imem_req_valid=0 throughout; dec_ready=1 -> dec_valid 0 next cycle, request 0x8 follows.
- Redirect to 0x103 while in WAIT, rsp arrives 2 cycles later with 0xFFFFFFFF -> word discarded, dec_valid stays 0, next imem_addr=0x100.
- Redirect in same cycle as imem_req_ready -> response dropped, next request 0x40 for redirect_pc=0x40.
- RESET_PC=0xFFFFFFFC, fetch/consume one instr -> next imem_addr=0x00000000.
- nreset low for 1 cycle while in WAIT/HOLD -> next cycle dec_valid=0, fields 0, IDLE then request at RESET_PC; with IFETCH_PERF_EN, 3 handshakes + 1 dropped -> fetch_count=3, reset clears to 0.
